// File: rtl/ct_display_scan_pkg.sv
// Shared constants and helpers for the ciphertext display scanner.
package ct_display_scan_pkg;

  localparam int unsigned CT_W                 = 128;
  localparam int unsigned DIGIT_IDX_W          = 3;
  localparam int unsigned PAGE_W               = 2;
  localparam logic [7:0]  ANODE_OFF            = 8'hFF;
  localparam int unsigned REFRESH_BITS_DEFAULT = 18;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [7:0] anode_onehot(input logic [DIGIT_IDX_W-1:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/ct_display_scan_capture_reg.sv
// Holding register for the encryption result: latches ciphertext and tag on each new done rise.
module ct_capture_reg
  import ct_display_scan_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [CT_W-1:0] ct,
  input  logic            ct_tag,
  input  logic            ct_done,
  input  logic            hold,
  output logic [CT_W-1:0] ct_reg,
  output logic            tag_led,
  output logic            captured
);

  logic            done_q;
  logic            rise;
  logic            load;
  logic [CT_W-1:0] ct_reg_q;
  logic            tag_q;
  logic            captured_q;

  // A rise seen while hold is set is simply dropped, never deferred.
  assign rise = ct_done & ~done_q;
  assign load = rise & ~hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      ct_reg_q   <= '0;
      tag_q      <= 1'b0;
      captured_q <= 1'b0;
    end else begin
      done_q <= ct_done;
      if (load) begin
        ct_reg_q   <= ct;
        tag_q      <= ct_tag;
        captured_q <= 1'b1;
      end
    end
  end

  assign ct_reg   = ct_reg_q;
  assign tag_led  = tag_q;
  assign captured = captured_q;

endmodule

// File: rtl/ct_display_scan.sv
// Eight-digit seven-segment scanner showing one 32-bit page of the held ciphertext.
module ct_display_scan
  import ct_display_scan_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = REFRESH_BITS_DEFAULT,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CT_W-1:0]   ct,
  input  logic              ct_tag,
  input  logic              ct_done,
  input  logic              hold,
  input  logic [PAGE_W-1:0] page_sel,
  input  logic              blank,
  output logic [7:0]        An,
  output logic [3:0]        hex_digit,
  output logic              captured,
  output logic              tag_led
);

  logic [CT_W-1:0]         ct_reg;
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [DIGIT_IDX_W-1:0]  idx_q, idx_d;
  logic [PAGE_W-1:0]       page_q, page_d;
  logic [7:0]              an_q, an_d;
  logic [3:0]              hex_q, hex_d;
  logic                    tick;
  logic                    scan_wrap;

  ct_capture_reg u_capture (
    .clk      (clk),
    .rst      (rst),
    .ct       (ct),
    .ct_tag   (ct_tag),
    .ct_done  (ct_done),
    .hold     (hold),
    .ct_reg   (ct_reg),
    .tag_led  (tag_led),
    .captured (captured)
  );

  assign tick      = &cnt_q;
  assign scan_wrap = tick && (idx_q == DIGIT_IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    page_d = page_q;
    an_d   = ANODE_OFF;
    hex_d  = 4'h0;
    if (tick) begin
      idx_d = idx_q + 1'b1;
    end
    // Page only moves at a scan boundary so a full scan never mixes two pages.
    if (scan_wrap || !captured) begin
      page_d = page_sel;
    end
    if (!blank && captured) begin
      an_d  = anode_onehot(idx_q);
      hex_d = ct_reg[{page_q, idx_q, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      page_q <= '0;
      an_q   <= ANODE_OFF;
      hex_q  <= 4'h0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      page_q <= page_d;
      an_q   <= an_d;
      hex_q  <= hex_d;
    end
  end

  assign An        = an_q;
  assign hex_digit = hex_q;

endmodule

// File: tb/tb_ct_display_scan.sv
// Scoreboard bench for ct_display_scan with a cycle-count reference model (dwell of 4 clocks).
module tb_ct_display_scan;

  localparam int unsigned RB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] ct = '0;
  logic         ct_tag = 1'b0;
  logic         ct_done = 1'b0;
  logic         hold = 1'b0;
  logic [1:0]   page_sel = 2'd0;
  logic         blank = 1'b0;
  logic [7:0]   An;
  logic [3:0]   hex_digit;
  logic         captured;
  logic         tag_led;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] hex;
    logic       cap;
    logic       tag;
  } exp_t;

  localparam exp_t RESET_EXP = '{an: 8'hFF, hex: 4'h0, cap: 1'b0, tag: 1'b0};

  exp_t exp_q[$];

  ct_display_scan #(
    .REFRESH_BITS (RB),
    .NUM_DIGITS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ct        (ct),
    .ct_tag    (ct_tag),
    .ct_done   (ct_done),
    .hold      (hold),
    .page_sel  (page_sel),
    .blank     (blank),
    .An        (An),
    .hex_digit (hex_digit),
    .captured  (captured),
    .tag_led   (tag_led)
  );

  always #5 clk = ~clk;

  // Reference model: k counts clock edges since reset; each digit dwells 4 edges, a scan is 32.
  int           m_k = 0;
  logic [127:0] m_held = '0;
  logic         m_tag = 1'b0;
  logic         m_cap = 1'b0;
  logic         m_prev = 1'b0;
  int           m_page = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k = 0; m_held = '0; m_tag = 1'b0; m_cap = 1'b0; m_prev = 1'b0; m_page = 0;
      exp_q.delete();
    end else begin
      exp_t         e;
      int           digit;
      logic [127:0] sh;
      digit = (m_k / 4) % 8;
      sh    = m_held >> (m_page * 32 + digit * 4);
      if (blank || !m_cap) begin
        e.an  = 8'hFF;
        e.hex = 4'h0;
      end else begin
        e.an  = 8'hFF ^ (8'd1 << digit);
        e.hex = sh[3:0];
      end
      if ((m_k % 32) == 31 || !m_cap) m_page = int'(page_sel);
      if (ct_done && !m_prev && !hold) begin
        m_held = ct;
        m_tag  = ct_tag;
        m_cap  = 1'b1;
      end
      m_prev = ct_done;
      e.cap  = m_cap;
      e.tag  = m_tag;
      exp_q.push_back(e);
      m_k++;
    end
  end

  // Monitor: the display presents a new output every clock; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst || exp_q.size() == 0) e = RESET_EXP;
    else e = exp_q.pop_front();
    checks++;
    if ({An, hex_digit, captured, tag_led} !== {e.an, e.hex, e.cap, e.tag}) begin
      errors++;
      $display("FAIL scan t=%0t: An=%h hex=%h cap=%b tag=%b, expected An=%h hex=%h cap=%b tag=%b",
               $time, An, hex_digit, captured, tag_led, e.an, e.hex, e.cap, e.tag);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_done();
    ct_done = 1'b1;
    step(1);
    ct_done = 1'b0;
    step(1);
  endtask

  task automatic async_reset_check(input string name);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({An, hex_digit, captured, tag_led} !== {8'hFF, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: An=%h hex=%h cap=%b tag=%b, expected FF/0/0/0",
               name, An, hex_digit, captured, tag_led);
    end
    #1 rst = 1'b1;
    step(1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    step(3);
    rst = 1'b1;
    // Idle: dark display with no completion.
    step(100);

    // Capture and scan page 0.
    ct       = 128'h0123456789ABCDEF_FEDCBA98_76543210;
    ct_tag   = 1'b1;
    page_sel = 2'd0;
    pulse_done();
    step(40);

    // Reset mid-scan, then recapture.
    async_reset_check("async_reset_mid_scan");
    step(20);
    pulse_done();
    step(17);

    // Page change mid-scan takes effect at the next scan start.
    page_sel = 2'd3;
    step(64);

    // Hold discards a rise and does not remember it.
    hold   = 1'b1;
    ct     = 128'h1;
    ct_tag = 1'b0;
    pulse_done();
    step(10);
    hold = 1'b0;
    step(40);
    page_sel = 2'd0;
    pulse_done();
    step(40);

    // Level done: only the value present at the rise is latched.
    ct_done = 1'b1;
    ct      = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    ct_tag  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      ct     = rand128();
      ct_tag = 1'($urandom);
    end
    ct_done = 1'b0;
    step(40);

    // Blank does not disturb the scan phase.
    step(3);
    blank = 1'b1;
    step(10);
    blank = 1'b0;
    step(40);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) ct_done = ~ct_done;
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      if ($urandom_range(0, 20) == 0) blank = ~blank;
      if ($urandom_range(0, 25) == 0) page_sel = 2'($urandom);
      ct     = rand128();
      ct_tag = 1'($urandom);
      step(1);
      if (i == 800) async_reset_check("async_reset_random");
    end
    hold    = 1'b0;
    blank   = 1'b0;
    ct_done = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
